activation_streamer: RTL and testbench

ACTIVATION_STREAMER -- requirements
Module: activation_streamer

---
 rtl/activation_streamer_pkg.sv | 19 +
 rtl/stream_frame_buf.sv | 32 +++
 rtl/activation_streamer.sv | 152 +++++++++++++++
 tb/tb_activation_streamer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/activation_streamer_pkg.sv
// activation_streamer_pkg: state encoding and address-width helper shared by the
//   activation streamer top and its frame buffer.
// Contents: stream_state_t (IDLE/STREAM/DRAIN/DONE), frame_addr_w(side).
package activation_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } stream_state_t;

  // Address width for a side x side frame; never narrower than one bit.
  function automatic int frame_addr_w(input int side);
    if (side * side <= 2) return 1;
    return $clog2(side * side);
  endfunction

endpackage

// File: rtl/stream_frame_buf.sv
// stream_frame_buf: DEPTH x WIDTH frame store, one synchronous write port and
//   one registered read port (write-first on address collision), no reset.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr in, rd_data registered out.
module stream_frame_buf
  import activation_streamer_pkg::*;
#(
  parameter int DEPTH = 36,
  parameter int WIDTH = 16,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Forward a same-cycle write so a frame launched together with a write to
  // word 0 already sees the new value on its first beat.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr == rd_addr)) rd_data <= wr_data;
    else                               rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/activation_streamer.sv
// activation_streamer: streams an n*n activation frame from a local buffer into
//   an accelerator under clock-enable control, then waits for its end-of-op.
// Ports: clk, global_rst_n (sync, active-low); wr_en/wr_addr/wr_data buffer load
//   (IDLE only); start, pause, acc_end controls; ce, activation, busy, done, timeout.
// Optional: define STREAMER_TIMEOUT_EN for the DRAIN watchdog (else timeout=0).
module activation_streamer
  import activation_streamer_pkg::*;
#(
  parameter  int n       = 6,
  parameter  int N       = 16,
  parameter  int TIMEOUT = 64,
  localparam int ADDR_W  = frame_addr_w(n)
) (
  input  logic              clk,
  input  logic              global_rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [N-1:0]      wr_data,
  input  logic              start,
  input  logic              pause,
  input  logic              acc_end,
  output logic              ce,
  output logic [N-1:0]      activation,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int                WORDS     = n * n;
  localparam logic [ADDR_W:0]   WORDS_CNT = (ADDR_W + 1)'(WORDS);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(WORDS - 1);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("activation_streamer: TIMEOUT must be at least 1");
  end

  stream_state_t     state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              paused_q;
  logic              run;
  logic              consume;
  logic              buf_wr;
  logic              wd_expire;
  logic [N-1:0]      rd_data;

  // ce for the current cycle is the registered inverse of last cycle's pause.
  assign run     = !paused_q;
  // A word counts as issued only in a STREAM cycle where ce is high, so a
  // pause never drops or repeats a word seen with ce=1.
  assign consume = (state == STREAM) && run;
  assign buf_wr  = (state == IDLE) && wr_en && ({1'b0, wr_addr} < WORDS_CNT);

  // Read address is the index of the word to present next cycle.
  always_comb begin
    idx_nxt = '0;
    if (state == STREAM) begin
      if (!consume)              idx_nxt = idx;
      else if (idx != LAST_IDX)  idx_nxt = idx + ADDR_W'(1);
    end
  end

  stream_frame_buf #(
    .DEPTH (WORDS),
    .WIDTH (N),
    .AW    (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_wr),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_nxt),
    .rd_data (rd_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!global_rst_n) state <= IDLE;
    else               state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (consume && (idx == LAST_IDX)) state_nxt = DRAIN;
      DRAIN:   if (acc_end || wd_expire) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ce         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    activation = '0;
    case (state)
      STREAM: begin
        ce         = run;
        busy       = 1'b1;
        activation = rd_data;
      end
      DRAIN: begin
        ce   = run;
        busy = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!global_rst_n) begin
      idx      <= '0;
      paused_q <= 1'b0;
    end else begin
      idx      <= idx_nxt;
      paused_q <= pause && ((state == STREAM) || (state == DRAIN));
    end
  end

`ifdef STREAMER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  // Counts only DRAIN cycles with ce high; paused cycles do not age the frame.
  always_ff @(posedge clk) begin
    if (!global_rst_n)       wd_cnt <= '0;
    else if (state != DRAIN) wd_cnt <= '0;
    else if (run)            wd_cnt <= wd_cnt + WD_W'(1);
  end

  assign wd_expire = (state == DRAIN) && run && (wd_cnt == WD_W'(TIMEOUT - 1));

  // acc_end in the expiry cycle wins: a normal completion, no timeout flag.
  always_ff @(posedge clk) begin
    if (!global_rst_n)                   timeout_q <= 1'b0;
    else if ((state == IDLE) && start)   timeout_q <= 1'b0;
    else if (wd_expire && !acc_end)      timeout_q <= 1'b1;
  end

  assign timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_activation_streamer.sv
// tb_activation_streamer: scoreboard bench for activation_streamer (n=6, N=16).
// Stimulus pushes each frame's expected words; a negedge monitor pops on ce=1.
// Build with STREAMER_TIMEOUT_EN to exercise the watchdog at TIMEOUT=8.
module tb_activation_streamer;

  localparam int NS    = 6;
  localparam int WORDS = NS * NS;
`ifdef STREAMER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic        clk = 1'b0;
  logic        global_rst_n;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic        pause;
  logic        acc_end;
  logic        ce;
  logic [15:0] activation;
  logic        busy;
  logic        done;
  logic        timeout;

  always #5 clk = ~clk;

  activation_streamer #(.n(NS), .N(16), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .global_rst_n (global_rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .pause        (pause),
    .acc_end      (acc_end),
    .ce           (ce),
    .activation   (activation),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout)
  );

  logic [15:0] model [WORDS];
  logic [15:0] exp_q [$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, got, want);
  endtask

  // Monitor: every ce=1 beat consumes one expected word; with nothing
  // outstanding the streamer must be draining and present zero.
  always @(negedge clk) begin
    if (ce === 1'b1) begin
      if (exp_q.size() > 0) chk("stream_word", 32'(activation), 32'(exp_q.pop_front()));
      else                  chk("drain_activation", 32'(activation), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit: got no finish, want finish before 100us");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    for (int i = 0; i < WORDS; i++) exp_q.push_back(model[i]);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic stream(input int cycles, output int lows);
    lows = 0;
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk);
      if (ce !== 1'b1) lows++;
      cyc();
    end
  endtask

  // Entered at drain cycle 1; raises acc_end in drain cycle d_end.
  task automatic end_frame(input int d_end);
    for (int d = 1; d <= d_end; d++) begin
      @(negedge clk);
      if (d == 1) chk("drain_entry_busy_ce", 32'({busy, ce}), 32'b11);
      if (d == d_end) acc_end = 1'b1;
      cyc();
      acc_end = 1'b0;
    end
    @(negedge clk);
    chk("done_pulse_done_ce_busy", 32'({done, ce, busy}), 32'b100);
    cyc();
    @(negedge clk);
    chk("after_done_idle", 32'({done, ce, busy}), 32'b000);
    chk("frame_words_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int lows;
    int done_at;
    int to_at;
    int bad;
    global_rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; pause = 1'b0; acc_end = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    chk("reset_outputs", 32'({ce, busy, done, timeout, activation}), 32'd0);
    global_rst_n = 1'b1;
    cyc();

    // Load buf[i] = i
    for (int i = 0; i < WORDS; i++) begin
      wr_en = 1'b1; wr_addr = 6'(i); wr_data = 16'(i); model[i] = 16'(i);
      cyc();
    end
    wr_en = 1'b0;

    // Plain frame: 36 gap-free words one cycle after start, acc_end 5 cycles into DRAIN
    start_frame();
    stream(WORDS, lows);
    chk("plain_ce_low_cycles", 32'(lows), 32'd0);
    chk("plain_words_left", 32'(exp_q.size()), 32'd0);
    end_frame(5);

    // Pause: held 3 cycles so word 10 sits with ce=0, then resumes at word 10
    cyc();
    start_frame();
    lows = 0;
    for (int c = 1; c <= WORDS + 3; c++) begin
      @(negedge clk);
      if (ce !== 1'b1) lows++;
      if (c >= 11 && c <= 13) chk("pause_hold_ce_act", 32'({ce, activation}), 32'd10);
      pause = (c >= 10 && c <= 12);
      cyc();
    end
    chk("pause_ce_low_cycles", 32'(lows), 32'd3);
    chk("pause_words_left", 32'(exp_q.size()), 32'd0);
    // acc_end together with pause in the first DRAIN cycle still completes
    @(negedge clk);
    chk("pause_drain_entry", 32'({busy, ce}), 32'b11);
    pause = 1'b1; acc_end = 1'b1;
    cyc();
    pause = 1'b0; acc_end = 1'b0;
    @(negedge clk);
    chk("paused_done_pulse", 32'({done, ce, busy}), 32'b100);
    cyc();
    @(negedge clk);
    chk("paused_after_done", 32'({done, busy}), 32'b00);

    // Ignored inputs: out-of-range write, writes and start while busy
    cyc();
    wr_en = 1'b1; wr_addr = 6'd36; wr_data = 16'hBEEF;
    cyc();
    wr_addr = 6'd5; wr_data = 16'h0500; model[5] = 16'h0500;
    cyc();
    wr_addr = 6'd0; wr_data = 16'h1234; model[0] = 16'h1234;
    start_frame();
    wr_en = 1'b0;
    lows = 0;
    for (int c = 1; c <= WORDS; c++) begin
      @(negedge clk);
      if (ce !== 1'b1) lows++;
      if (c == 3) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 6'd7; wr_data = 16'hDEAD;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      cyc();
    end
    chk("busy_ignore_ce_low_cycles", 32'(lows), 32'd0);
    chk("busy_ignore_words_left", 32'(exp_q.size()), 32'd0);
    end_frame(1);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      if (ce !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("stray_start_no_frame", 32'(bad), 32'd0);

    // Reset at word 20 aborts without done; buffer survives the reset
    cyc();
    start_frame();
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 21) global_rst_n = 1'b0;
      cyc();
    end
    @(negedge clk);
    chk("reset_abort_outputs", 32'({ce, busy, done, activation}), 32'd0);
    chk("reset_abort_words_left", 32'(exp_q.size()), 32'd15);
    exp_q.delete();
    global_rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("reset_no_done", 32'(bad), 32'd0);
    cyc();
    start_frame();
    stream(WORDS, lows);
    chk("replay_ce_low_cycles", 32'(lows), 32'd0);
    chk("replay_words_left", 32'(exp_q.size()), 32'd0);
    end_frame(2);

`ifdef STREAMER_TIMEOUT_EN
    // Watchdog: 8 unpaused DRAIN cycles without acc_end, done on the 9th
    cyc();
    start_frame();
    stream(WORDS, lows);
    chk("wd_ce_low_cycles", 32'(lows), 32'd0);
    done_at = 0;
    to_at = 0;
    for (int d = 1; d <= 40; d++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_at = d;
        to_at = int'(timeout);
        break;
      end
      cyc();
    end
    chk("wd_done_cycle", 32'(done_at), 32'd9);
    chk("wd_timeout_at_done", 32'(to_at), 32'd1);
    cyc();
    @(negedge clk);
    chk("wd_timeout_sticky_idle", 32'({timeout, busy}), 32'b10);
    cyc();
    start_frame();
    @(negedge clk);
    chk("wd_timeout_cleared_by_start", 32'({timeout, ce}), 32'b01);
    cyc();
    stream(WORDS - 1, lows);
    chk("wd_next_frame_ce_low", 32'(lows), 32'd0);
    end_frame(1);
`else
    // Without the watchdog DRAIN waits indefinitely for acc_end
    cyc();
    start_frame();
    stream(WORDS, lows);
    chk("nowd_ce_low_cycles", 32'(lows), 32'd0);
    bad = 0;
    for (int d = 1; d <= 70; d++) begin
      @(negedge clk);
      if (done !== 1'b0 || timeout !== 1'b0) bad++;
      cyc();
    end
    chk("nowd_no_done_or_timeout", 32'(bad), 32'd0);
    @(negedge clk);
    chk("nowd_still_draining", 32'({busy, ce}), 32'b11);
    cyc();
    end_frame(1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
